// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: walks RESET -> T0..T7 -> T0/HALT, decoding IR[31:27] for execute steps.
// Latency: one state per clock; memory steps (T1, ld T6, st T7) are held for MEM_WAIT+1 cycles.
// Backpressure: none; Stop is honoured only at instruction end and HALT is left only through clear.
module control_sequencer #(
   parameter int MEM_WAIT = 0
) (
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        Stop,
   output logic        Run,
   output logic [4:0]  opcode,
   output logic        Gra, Grb, Grc, Rin, Rout, BAout,
   output logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin,
   output logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout,
   output logic        Read, Write, IncPC
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam int            WW        = $clog2(MEM_WAIT + 2);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT);

   state_t        state_q;
   logic [WW-1:0] wait_q;

   logic [4:0] op;
   logic       unused_ir;
   assign op        = IR[31:27];
   assign unused_ir = ^IR[26:0];

   // Instruction classes; anything not listed (nop and undefined codes) has no execute phase.
   logic op_alu, op_imm, op_md, op_ld, op_ldi, op_st, op_br, op_jr, op_jal;
   logic op_in, op_out, op_mfhi, op_mflo, op_halt, op_none, op_ldst;
   assign op_alu  = (op >= 5'd3) && (op <= 5'd11);
   assign op_imm  = (op >= 5'd12) && (op <= 5'd14);
   assign op_md   = (op == 5'd15) || (op == 5'd16);
   assign op_ld   = (op == 5'd0);
   assign op_ldi  = (op == 5'd1);
   assign op_st   = (op == 5'd2);
   assign op_br   = (op == 5'd18);
   assign op_jr   = (op == 5'd19);
   assign op_jal  = (op == 5'd20);
   assign op_in   = (op == 5'd21);
   assign op_out  = (op == 5'd22);
   assign op_mfhi = (op == 5'd23);
   assign op_mflo = (op == 5'd24);
   assign op_halt = (op == 5'd26);
   assign op_ldst = op_ld | op_ldi | op_st;
   assign op_none = !(op_alu | op_imm | op_md | op_ldst | op_br | op_jr | op_jal |
                      op_in | op_out | op_mfhi | op_mflo | op_halt);

   // Final execute step of the decoded instruction.
   state_t last_st;
   always_comb begin
      last_st = S_T3;
      if (op_alu | op_imm | op_ldi) last_st = S_T5;
      else if (op_md | op_br)       last_st = S_T6;
      else if (op_ld | op_st)       last_st = S_T7;
      else if (op_jal)              last_st = S_T4;
   end

   logic mem_hold;
   assign mem_hold = (state_q == S_T1) || (state_q == S_T6 && op_ld) || (state_q == S_T7 && op_st);

   // Sequencer: state advance, wait-state counting, instruction-end Stop sampling.
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_RESET;
         wait_q  <= '0;
      end else begin
         case (state_q)
            S_RESET: state_q <= S_T0;
            S_HALT:  state_q <= S_HALT;
            S_T2: begin
               wait_q <= '0;
               if (op_halt)      state_q <= S_HALT;
               else if (op_none) state_q <= Stop ? S_HALT : S_T0;
               else              state_q <= S_T3;
            end
            default: begin
               if (mem_hold && wait_q != WAIT_LAST) begin
                  wait_q <= wait_q + 1'b1;
               end else begin
                  wait_q <= '0;
                  if (state_q >= S_T3 && state_q >= last_st) state_q <= Stop ? S_HALT : S_T0;
                  else                                       state_q <= state_t'(state_q + 4'd1);
               end
            end
         endcase
      end
   end

   // Moore output decode of state and instruction class.
   always_comb begin
      Run = 1'b0; opcode = 5'd0;
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      HIin = 1'b0; LOin = 1'b0; Yin = 1'b0; Zin = 1'b0; PCin = 1'b0; IRin = 1'b0;
      MARin = 1'b0; MDRin = 1'b0; Inportin = 1'b0; Outportin = 1'b0; CONin = 1'b0;
      HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; PCout = 1'b0;
      MDRout = 1'b0; Inportout = 1'b0; Cout = 1'b0;
      Read = 1'b0; Write = 1'b0; IncPC = 1'b0;
      case (state_q)
         S_T0: begin Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         S_T1: begin Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            Run = 1'b1;
            if (op_alu | op_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            if (op_md)           begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            if (op_ldst)         begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            if (op_br)           begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            if (op_jr)           begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            if (op_jal)          begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
            if (op_in)           begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            if (op_out)          begin Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1; end
            if (op_mfhi)         begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            if (op_mflo)         begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
         end
         S_T4: begin
            Run = 1'b1;
            if (op_alu)  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
            if (op_imm)  begin Cout = 1'b1; Zin = 1'b1; opcode = op; end
            if (op_md)   begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
            if (op_ldst) begin Cout = 1'b1; Zin = 1'b1; opcode = 5'b00011; end
            if (op_br)   begin PCout = 1'b1; Yin = 1'b1; end
            if (op_jal)  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
         end
         S_T5: begin
            Run = 1'b1;
            if (op_alu | op_imm | op_ldi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            if (op_md)                    begin Zlowout = 1'b1; LOin = 1'b1; end
            if (op_ld | op_st)            begin Zlowout = 1'b1; MARin = 1'b1; end
            if (op_br)                    begin Cout = 1'b1; Zin = 1'b1; opcode = 5'b00011; end
         end
         S_T6: begin
            Run = 1'b1;
            if (op_md) begin Zhighout = 1'b1; HIin = 1'b1; end
            if (op_ld) begin Read = 1'b1; MDRin = 1'b1; end
            if (op_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            if (op_br) begin Zlowout = 1'b1; PCin = CON_FF; end
         end
         S_T7: begin
            Run = 1'b1;
            if (op_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            if (op_st) Write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_WAIT=0 and 2) share stimulus and are checked
// cycle by cycle against a queue of expected control words built from the instruction tables.
// Each instruction is started from a clear pulse so both instances begin in step.
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] IR = 32'd0;
   logic        CON_FF = 1'b0;
   logic        Stop = 1'b0;

   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;

   // Control flag bit positions in the packed observation word.
   localparam logic [27:0] GRA = 28'd1 << 0,  GRB = 28'd1 << 1,  GRC = 28'd1 << 2,  RIN = 28'd1 << 3;
   localparam logic [27:0] ROUT = 28'd1 << 4, BAOUT = 28'd1 << 5, HIIN = 28'd1 << 6, LOIN = 28'd1 << 7;
   localparam logic [27:0] YIN = 28'd1 << 8,  ZIN = 28'd1 << 9,  PCIN = 28'd1 << 10, IRIN = 28'd1 << 11;
   localparam logic [27:0] MARIN = 28'd1 << 12, MDRIN = 28'd1 << 13, INPORTIN = 28'd1 << 14;
   localparam logic [27:0] OUTPORTIN = 28'd1 << 15, CONIN = 28'd1 << 16, HIOUT = 28'd1 << 17;
   localparam logic [27:0] LOOUT = 28'd1 << 18, ZHIGHOUT = 28'd1 << 19, ZLOWOUT = 28'd1 << 20;
   localparam logic [27:0] PCOUT = 28'd1 << 21, MDROUT = 28'd1 << 22, INPORTOUT = 28'd1 << 23;
   localparam logic [27:0] COUT = 28'd1 << 24, READ = 28'd1 << 25, WRITE = 28'd1 << 26, INCPC = 28'd1 << 27;

   localparam logic [33:0] FETCH0 = {1'b1, 5'd0, PCOUT | MARIN | INCPC | ZIN};

   wire [27:0] f0, f2;
   wire [4:0]  oc0, oc2;
   wire        r0, r2;
   logic [33:0] obs0, obs2;
   assign obs0 = {r0, oc0, f0};
   assign obs2 = {r2, oc2, f2};

   control_sequencer #(.MEM_WAIT(0)) dut0 (
      .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
      .Run(r0), .opcode(oc0),
      .Gra(f0[0]), .Grb(f0[1]), .Grc(f0[2]), .Rin(f0[3]), .Rout(f0[4]), .BAout(f0[5]),
      .HIin(f0[6]), .LOin(f0[7]), .Yin(f0[8]), .Zin(f0[9]), .PCin(f0[10]), .IRin(f0[11]),
      .MARin(f0[12]), .MDRin(f0[13]), .Inportin(f0[14]), .Outportin(f0[15]), .CONin(f0[16]),
      .HIout(f0[17]), .LOout(f0[18]), .Zhighout(f0[19]), .Zlowout(f0[20]), .PCout(f0[21]),
      .MDRout(f0[22]), .Inportout(f0[23]), .Cout(f0[24]),
      .Read(f0[25]), .Write(f0[26]), .IncPC(f0[27])
   );

   control_sequencer #(.MEM_WAIT(2)) dut2 (
      .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
      .Run(r2), .opcode(oc2),
      .Gra(f2[0]), .Grb(f2[1]), .Grc(f2[2]), .Rin(f2[3]), .Rout(f2[4]), .BAout(f2[5]),
      .HIin(f2[6]), .LOin(f2[7]), .Yin(f2[8]), .Zin(f2[9]), .PCin(f2[10]), .IRin(f2[11]),
      .MARin(f2[12]), .MDRin(f2[13]), .Inportin(f2[14]), .Outportin(f2[15]), .CONin(f2[16]),
      .HIout(f2[17]), .LOout(f2[18]), .Zhighout(f2[19]), .Zlowout(f2[20]), .PCout(f2[21]),
      .MDRout(f2[22]), .Inportout(f2[23]), .Cout(f2[24]),
      .Read(f2[25]), .Write(f2[26]), .IncPC(f2[27])
   );

   function automatic logic [33:0] cw(input logic [4:0] opc, input logic [27:0] f);
      return {1'b1, opc, f};
   endfunction

   // Reference model: expected per-cycle control words for one instruction, fetch included.
   logic [33:0] model_q[$];
   logic        model_halt;

   task automatic build(input logic [31:0] ir, input logic con, input int mw);
      logic [4:0] o;
      o = ir[31:27];
      model_q.delete();
      model_halt = (o == 5'd26);
      model_q.push_back(FETCH0);
      repeat (mw + 1) model_q.push_back(cw(5'd0, ZLOWOUT | PCIN | READ | MDRIN));
      model_q.push_back(cw(5'd0, MDROUT | IRIN));
      if (o >= 5'd3 && o <= 5'd11) begin
         model_q.push_back(cw(5'd0, GRB | ROUT | YIN));
         model_q.push_back(cw(o, GRC | ROUT | ZIN));
         model_q.push_back(cw(5'd0, ZLOWOUT | GRA | RIN));
      end else if (o >= 5'd12 && o <= 5'd14) begin
         model_q.push_back(cw(5'd0, GRB | ROUT | YIN));
         model_q.push_back(cw(o, COUT | ZIN));
         model_q.push_back(cw(5'd0, ZLOWOUT | GRA | RIN));
      end else if (o == 5'd15 || o == 5'd16) begin
         model_q.push_back(cw(5'd0, GRA | ROUT | YIN));
         model_q.push_back(cw(o, GRB | ROUT | ZIN));
         model_q.push_back(cw(5'd0, ZLOWOUT | LOIN));
         model_q.push_back(cw(5'd0, ZHIGHOUT | HIIN));
      end else if (o <= 5'd2) begin
         model_q.push_back(cw(5'd0, GRB | BAOUT | YIN));
         model_q.push_back(cw(5'd3, COUT | ZIN));
         if (o == 5'd1) begin
            model_q.push_back(cw(5'd0, ZLOWOUT | GRA | RIN));
         end else begin
            model_q.push_back(cw(5'd0, ZLOWOUT | MARIN));
            if (o == 5'd0) begin
               repeat (mw + 1) model_q.push_back(cw(5'd0, READ | MDRIN));
               model_q.push_back(cw(5'd0, MDROUT | GRA | RIN));
            end else begin
               model_q.push_back(cw(5'd0, GRA | ROUT | MDRIN));
               repeat (mw + 1) model_q.push_back(cw(5'd0, WRITE));
            end
         end
      end else if (o == 5'd18) begin
         model_q.push_back(cw(5'd0, GRA | ROUT | CONIN));
         model_q.push_back(cw(5'd0, PCOUT | YIN));
         model_q.push_back(cw(5'd3, COUT | ZIN));
         model_q.push_back(cw(5'd0, ZLOWOUT | (con ? PCIN : 28'd0)));
      end else if (o == 5'd19) model_q.push_back(cw(5'd0, GRA | ROUT | PCIN));
      else if (o == 5'd20) begin
         model_q.push_back(cw(5'd0, PCOUT | GRB | RIN));
         model_q.push_back(cw(5'd0, GRA | ROUT | PCIN));
      end
      else if (o == 5'd21) model_q.push_back(cw(5'd0, INPORTOUT | GRA | RIN));
      else if (o == 5'd22) model_q.push_back(cw(5'd0, GRA | ROUT | OUTPORTIN));
      else if (o == 5'd23) model_q.push_back(cw(5'd0, HIOUT | GRA | RIN));
      else if (o == 5'd24) model_q.push_back(cw(5'd0, LOOUT | GRA | RIN));
   endtask

   task automatic chk(input string tag, input int cyc, input logic [33:0] obs, input logic [33:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // Clear pulse, then run one instruction on both instances; stop_at<0 leaves Stop low.
   task automatic run_instr(input string tag, input logic [31:0] ir, input logic con, input int stop_at);
      logic [33:0] q0[$];
      logic [33:0] q2[$];
      logic [33:0] e;
      logic        h;
      clear  = 1'b0;
      Stop   = 1'b0;
      IR     = ir;
      CON_FF = con;
      @(negedge Clock);
      chk({tag, "_rst_w0"}, -1, obs0, 34'd0);
      chk({tag, "_rst_w2"}, -1, obs2, 34'd0);
      clear = 1'b1;
      build(ir, con, 0); q0 = model_q;
      build(ir, con, 2); q2 = model_q;
      h = model_halt || (stop_at >= 0);
      for (int c = 0; c <= q2.size(); c++) begin
         @(negedge Clock);
         if (c == stop_at) Stop = 1'b1;
         if (c <= q0.size()) begin
            e = (c < q0.size()) ? q0[c] : (h ? 34'd0 : FETCH0);
            chk({tag, "_w0"}, c, obs0, e);
         end
         e = (c < q2.size()) ? q2[c] : (h ? 34'd0 : FETCH0);
         chk({tag, "_w2"}, c, obs2, e);
      end
      if (h) begin
         Stop = 1'b0;
         repeat (2) begin
            @(negedge Clock);
            chk({tag, "_halt_w0"}, -2, obs0, 34'd0);
            chk({tag, "_halt_w2"}, -2, obs2, 34'd0);
         end
      end
      Stop = 1'b0;
   endtask

   initial begin
      logic [33:0] q0[$];
      logic [31:0] ir;

      // Asynchronous clear in the middle of add's T4.
      IR = 32'h1919_8000;
      @(negedge Clock);
      clear = 1'b1;
      build(IR, 1'b0, 0); q0 = model_q;
      repeat (5) @(negedge Clock);
      chk("add_t4_w0", 4, obs0, q0[4]);
      clear = 1'b0;
      #1;
      chk("midclr_w0", 4, obs0, 34'd0);
      chk("midclr_w2", 4, obs2, 34'd0);
      @(negedge Clock);
      chk("clrhold_w0", 5, obs0, 34'd0);
      clear = 1'b1;
      @(negedge Clock);
      chk("rel_t0_w0", 0, obs0, FETCH0);
      chk("rel_t0_w2", 0, obs2, FETCH0);

      // Directed instructions from the test plan.
      run_instr("add",  32'h1919_8000, 1'b0, -1);
      run_instr("ld",   32'h0088_0005, 1'b0, -1);
      run_instr("br0",  32'h9080_0010, 1'b0, -1);
      run_instr("br1",  32'h9080_0010, 1'b1, -1);
      run_instr("mul",  32'h8118_0000, 1'b0, -1);
      run_instr("ori_stop", 32'h7118_0007, 1'b0, 3);
      run_instr("halt", 32'hD000_0000, 1'b0, -1);

      // Every opcode once, then random instruction words.
      for (int o = 0; o < 32; o++) begin
         ir = $urandom;
         ir[31:27] = o[4:0];
         run_instr("op", ir, 1'($urandom_range(0, 1)), -1);
      end
      for (int i = 0; i < 24; i++) begin
         run_instr("rand", $urandom, 1'($urandom_range(0, 1)), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
